mips_instr_encoder: RTL

//  Encoding counterpart of the control decoder: turns a mnemonic plus register/immediate fields into a 32-bit MIPS word.

---
 rtl/mips_instr_encoder_pkg.sv | 42 ++++
 rtl/mips_instr_encoder_if.sv | 27 ++
 rtl/mips_field_pack.sv | 39 +++
 rtl/mips_instr_encoder.sv | 96 +++++++++
 4 files changed

// File: rtl/mips_instr_encoder_pkg.sv
// mips_instr_encoder_pkg: mnemonic codes, MIPS opcode/funct constants, encoder states, field packers
package mips_instr_encoder_pkg;

    // Codes 0..16 are legal; 17..31 are reported as illegal by the encoder.
    typedef enum logic [4:0] {
        M_ADD, M_SUB, M_AND, M_OR, M_SLT, M_JR, M_SYSCALL,
        M_ADDI, M_ADDIU, M_ORI, M_SLTIU, M_LW, M_SW, M_BEQ, M_BNE,
        M_J, M_JAL
    } mnem_e;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_SLT     = 6'h2A;

    typedef enum logic [1:0] {S_IDLE, S_ENCODE, S_EMIT, S_FULL} state_e;

    function automatic logic [31:0] r_word(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] fn);
        return {OP_SPECIAL, rs, rt, rd, 5'b0, fn};
    endfunction

    // Only imm[15:0] reaches the word; the upper immediate bits are dropped.
    function automatic logic [31:0] i_word(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [25:0] imm);
        return {op, rs, rt, imm[15:0]};
    endfunction

endpackage

// File: rtl/mips_instr_encoder_if.sv
// mips_instr_encoder_if: request and encoded-word streams of the instruction encoder
//   request : in_valid/in_ready with in_mnem, in_rs, in_rt, in_rd, in_imm
//   response: out_valid/out_ready with out_word, out_addr
//   master = requester/consumer side, slave = encoder side
interface mips_instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_mnem;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [25:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [31:0] out_addr;

    modport master (
        output in_valid, in_mnem, in_rs, in_rt, in_rd, in_imm, out_ready,
        input  in_ready, out_valid, out_word, out_addr
    );

    modport slave (
        input  in_valid, in_mnem, in_rs, in_rt, in_rd, in_imm, out_ready,
        output in_ready, out_valid, out_word, out_addr
    );
endinterface

// File: rtl/mips_field_pack.sv
// mips_field_pack: combinational mnemonic + fields -> 32-bit MIPS word and legal flag
//   mnem_i  mnemonic code, rs_i/rt_i/rd_i register fields, imm_i imm16 or jump target
//   word_o  encoded word (0 when illegal), legal_o mnemonic is supported
module mips_field_pack
    import mips_instr_encoder_pkg::*;
(
    input  logic [4:0]  mnem_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [25:0] imm_i,
    output logic [31:0] word_o,
    output logic        legal_o
);
    always_comb begin
        word_o  = '0;
        legal_o = 1'b1;
        case (mnem_e'(mnem_i))
            M_ADD:     word_o = r_word(rs_i, rt_i, rd_i, FN_ADD);
            M_SUB:     word_o = r_word(rs_i, rt_i, rd_i, FN_SUB);
            M_AND:     word_o = r_word(rs_i, rt_i, rd_i, FN_AND);
            M_OR:      word_o = r_word(rs_i, rt_i, rd_i, FN_OR);
            M_SLT:     word_o = r_word(rs_i, rt_i, rd_i, FN_SLT);
            M_JR:      word_o = r_word(rs_i, 5'b0, 5'b0, FN_JR);
            M_SYSCALL: word_o = r_word(5'b0, 5'b0, 5'b0, FN_SYSCALL);
            M_ADDI:    word_o = i_word(OP_ADDI, rs_i, rt_i, imm_i);
            M_ADDIU:   word_o = i_word(OP_ADDIU, rs_i, rt_i, imm_i);
            M_ORI:     word_o = i_word(OP_ORI, rs_i, rt_i, imm_i);
            M_SLTIU:   word_o = i_word(OP_SLTIU, rs_i, rt_i, imm_i);
            M_LW:      word_o = i_word(OP_LW, rs_i, rt_i, imm_i);
            M_SW:      word_o = i_word(OP_SW, rs_i, rt_i, imm_i);
            M_BEQ:     word_o = i_word(OP_BEQ, rs_i, rt_i, imm_i);
            M_BNE:     word_o = i_word(OP_BNE, rs_i, rt_i, imm_i);
            M_J:       word_o = {OP_J, imm_i};
            M_JAL:     word_o = {OP_JAL, imm_i};
            default:   legal_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder: encodes one mnemonic request at a time into a MIPS word streamed with its imem address
//   clk, reset (async, active-high), clear (sync: count 0, drop in-flight word, clear err)
//   bus   request/response streams (slave side)
//   full  IMEM_WORDS words emitted; err sticky illegal-mnemonic flag
module mips_instr_encoder
    import mips_instr_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          IMEM_WORDS = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    mips_instr_encoder_if.slave  bus,
    output logic                 full,
    output logic                 err
);
    localparam int CW = $clog2(IMEM_WORDS + 1);

    state_e         state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [31:0]    word_q, word_d, pack_word;
    logic           err_q, err_d, legal;
    logic [4:0]     mnem_q, rs_q, rt_q, rd_q;
    logic [25:0]    imm_q;

    mips_field_pack u_pack (
        .mnem_i  (mnem_q),
        .rs_i    (rs_q),
        .rt_i    (rt_q),
        .rd_i    (rd_q),
        .imm_i   (imm_q),
        .word_o  (pack_word),
        .legal_o (legal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            word_q  <= '0;
            err_q   <= 1'b0;
            mnem_q  <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            imm_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            word_q  <= word_d;
            err_q   <= err_d;
            if (!clear && state_q == S_IDLE && bus.in_valid) begin
                mnem_q <= bus.in_mnem;
                rs_q   <= bus.in_rs;
                rt_q   <= bus.in_rt;
                rd_q   <= bus.in_rd;
                imm_q  <= bus.in_imm;
            end
        end
    end

    // clear overrides everything, including a handshake in the same cycle.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        word_d  = word_q;
        err_d   = err_q;
        if (clear) begin
            state_d = S_IDLE;
            count_d = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE:   state_d = bus.in_valid ? S_ENCODE : S_IDLE;
                S_ENCODE: begin
                    word_d  = pack_word;
                    err_d   = err_q | ~legal;
                    state_d = legal ? S_EMIT : S_IDLE;
                end
                S_EMIT: if (bus.out_ready) begin
                    count_d = count_q + 1'b1;
                    state_d = (count_d == CW'(IMEM_WORDS)) ? S_FULL : S_IDLE;
                end
                default: state_d = state_q;
            endcase
        end
    end

    assign bus.in_ready  = state_q == S_IDLE;
    assign bus.out_valid = state_q == S_EMIT;
    assign bus.out_word  = word_q;
    assign bus.out_addr  = BASE_ADDR + (32'(count_q) << 2);
    assign full          = state_q == S_FULL;
    assign err           = err_q;
endmodule
